// File: rtl/bank_serial_reader.sv
// Serial-port read initiator for a 64 x 32 register bank. It shifts the selected
// register out LSB-first and can loop each bit back in so the read does not destroy the register.
module bank_serial_reader #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 6,
  parameter int SETTLE = 1
) (
  input  logic              clk_i,
  input  logic              reset_i,
  input  logic              req_valid_i,
  output logic              req_ready_o,
  input  logic [ADDR_W-1:0] req_addr_i,
  input  logic              req_restore_i,
  output logic              resp_valid_o,
  input  logic              resp_ready_i,
  output logic [WIDTH-1:0]  resp_data_o,
  output logic [ADDR_W-1:0] resp_addr_o,
  output logic              busy_o,
  output logic [ADDR_W-1:0] bank_reg_select_o,
  output logic              bank_output_enable_o,
  output logic              bank_shift_right_o,
  output logic              bank_serial_in_o,
  input  logic              bank_serial_out_i
);

  localparam int CNT_MAX = (WIDTH > SETTLE) ? WIDTH : SETTLE;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_SETUP = 2'd1;
  localparam logic [1:0] S_SHIFT = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [WIDTH-1:0]  data_q, data_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic              restore_q, restore_d;

  logic              req_ready_q, req_ready_d;
  logic              busy_q, busy_d;
  logic              resp_valid_q, resp_valid_d;
  logic [ADDR_W-1:0] sel_q, sel_d;
  logic              oe_q, oe_d;
  logic              shift_q, shift_d;

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    data_d    = data_q;
    addr_d    = addr_q;
    restore_d = restore_q;
    case (state_q)
      S_IDLE: begin
        if (req_valid_i && req_ready_q) begin
          addr_d    = req_addr_i;
          restore_d = req_restore_i;
          data_d    = '0;
          cnt_d     = CNT_W'(SETTLE);
          state_d   = S_SETUP;
        end
      end
      S_SETUP: begin
        if (cnt_q == CNT_W'(1)) begin
          cnt_d   = CNT_W'(WIDTH);
          state_d = S_SHIFT;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      S_SHIFT: begin
        // bank_serial_out still holds the pre-shift bit 0 at this edge
        data_d = {bank_serial_out_i, data_q[WIDTH-1:1]};
        cnt_d  = cnt_q - CNT_W'(1);
        if (cnt_q == CNT_W'(1)) begin
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (resp_ready_i) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    req_ready_d  = (state_d == S_IDLE);
    busy_d       = (state_d != S_IDLE);
    resp_valid_d = (state_d == S_DONE);
    oe_d         = (state_d == S_SETUP) || (state_d == S_SHIFT);
    shift_d      = (state_d == S_SHIFT);
    sel_d        = (state_d == S_IDLE) ? '0 : addr_d;
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      data_q       <= '0;
      addr_q       <= '0;
      restore_q    <= 1'b0;
      req_ready_q  <= 1'b1;
      busy_q       <= 1'b0;
      resp_valid_q <= 1'b0;
      sel_q        <= '0;
      oe_q         <= 1'b0;
      shift_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      data_q       <= data_d;
      addr_q       <= addr_d;
      restore_q    <= restore_d;
      req_ready_q  <= req_ready_d;
      busy_q       <= busy_d;
      resp_valid_q <= resp_valid_d;
      sel_q        <= sel_d;
      oe_q         <= oe_d;
      shift_q      <= shift_d;
    end
  end

  assign req_ready_o          = req_ready_q;
  assign busy_o               = busy_q;
  assign resp_valid_o         = resp_valid_q;
  assign resp_data_o          = data_q;
  assign resp_addr_o          = addr_q;
  assign bank_reg_select_o    = sel_q;
  assign bank_output_enable_o = oe_q;
  assign bank_shift_right_o   = shift_q;
  assign bank_serial_in_o     = bank_serial_out_i & restore_q & (state_q == S_SHIFT);

endmodule

// File: tb/tb_bank_serial_reader.sv
// Directed bench for bank_serial_reader: two DUTs (SETTLE=1 and SETTLE=3), each driving
// a behavioural 64 x 32 shift-register bank.
module tb_bank_serial_reader;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_valid1 = 1'b0;
  logic [5:0]  req_addr = '0;
  logic        req_restore = 1'b0;
  logic        resp_ready = 1'b0;

  logic        rready0, rvalid0, busy0, oe0, shift0, sin0, sout0;
  logic [31:0] rdata0;
  logic [5:0]  raddr0, sel0;
  logic        rready1, rvalid1, busy1, oe1, shift1, sin1, sout1;
  logic [31:0] rdata1;
  logic [5:0]  raddr1, sel1;

  logic [31:0] bank0 [64];
  logic [31:0] bank1 [64];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  bank_serial_reader #(.WIDTH(32), .ADDR_W(6), .SETTLE(1)) dut0 (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid), .req_ready_o(rready0), .req_addr_i(req_addr),
    .req_restore_i(req_restore), .resp_valid_o(rvalid0), .resp_ready_i(resp_ready),
    .resp_data_o(rdata0), .resp_addr_o(raddr0), .busy_o(busy0),
    .bank_reg_select_o(sel0), .bank_output_enable_o(oe0), .bank_shift_right_o(shift0),
    .bank_serial_in_o(sin0), .bank_serial_out_i(sout0)
  );

  bank_serial_reader #(.WIDTH(32), .ADDR_W(6), .SETTLE(3)) dut1 (
    .clk_i(clk), .reset_i(reset),
    .req_valid_i(req_valid1), .req_ready_o(rready1), .req_addr_i(req_addr),
    .req_restore_i(req_restore), .resp_valid_o(rvalid1), .resp_ready_i(resp_ready),
    .resp_data_o(rdata1), .resp_addr_o(raddr1), .busy_o(busy1),
    .bank_reg_select_o(sel1), .bank_output_enable_o(oe1), .bank_shift_right_o(shift1),
    .bank_serial_in_o(sin1), .bank_serial_out_i(sout1)
  );

  assign sout0 = oe0 ? bank0[sel0][0] : 1'b0;
  assign sout1 = oe1 ? bank1[sel1][0] : 1'b0;

  always @(posedge clk) begin
    if (oe0 && shift0) bank0[sel0] <= {sin0, bank0[sel0][31:1]};
    if (oe1 && shift1) bank1[sel1] <= {sin1, bank1[sel1][31:1]};
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    assert (got === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  // Waits for dut0 resp_valid; lat counts edges after the accept edge.
  task automatic wait_resp0(output int lat, output int shifts);
    lat = 0;
    shifts = 0;
    while (lat < 100) begin
      tick();
      lat++;
      if (shift0) shifts++;
      if (rvalid0) break;
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    int lat, shifts, lead, seen;

    for (int i = 0; i < 64; i++) begin
      bank0[i] = 32'h0;
      bank1[i] = 32'h0;
    end
    bank0[5]  = 32'hDEADBEEF;
    bank0[63] = 32'h80000001;
    bank0[10] = 32'h12345678;
    bank0[1]  = 32'h00000001;
    bank0[2]  = 32'hFFFFFFFF;
    bank0[7]  = 32'hA5A5A5A5;
    bank1[9]  = 32'hCAFEF00D;

    #1 reset = 1'b1;
    tick();
    tick();
    chk("rst_req_ready", rready0, 1);
    chk("rst_busy", busy0, 0);
    chk("rst_resp_valid", rvalid0, 0);
    chk("rst_oe", oe0, 0);
    chk("rst_shift", shift0, 0);
    chk("rst_sel", sel0, 0);
    chk("rst_data", rdata0, 0);
    chk("rst_addr", raddr0, 0);
    reset = 1'b0;
    tick();
    chk("post_rst_req_ready", rready0, 1);

    // Read 5 with restore, consumer always ready
    req_valid = 1'b1; req_addr = 6'd5; req_restore = 1'b1; resp_ready = 1'b1;
    tick();
    req_valid = 1'b0;
    chk("t1_busy", busy0, 1);
    chk("t1_req_ready", rready0, 0);
    chk("t1_setup_oe", oe0, 1);
    chk("t1_setup_shift", shift0, 0);
    chk("t1_sel", sel0, 5);
    wait_resp0(lat, shifts);
    chk("t1_latency", lat, 33);
    chk("t1_shift_cycles", shifts, 32);
    chk("t1_data", rdata0, 32'hDEADBEEF);
    chk("t1_addr", raddr0, 5);
    chk("t1_done_oe", oe0, 0);
    chk("t1_done_sel", sel0, 5);
    tick();
    chk("t1_idle_ready", rready0, 1);
    chk("t1_idle_busy", busy0, 0);
    chk("t1_idle_sel", sel0, 0);
    chk("t1_restored", bank0[5], 32'hDEADBEEF);

    // Destructive read of 63
    req_valid = 1'b1; req_addr = 6'd63; req_restore = 1'b0;
    tick();
    req_valid = 1'b0;
    wait_resp0(lat, shifts);
    chk("t2_latency", lat, 33);
    chk("t2_data", rdata0, 32'h80000001);
    chk("t2_addr", raddr0, 63);
    chk("t2_cleared", bank0[63], 32'h0);
    tick();

    // Consumer stalls 10 cycles; a request pulse in the window is dropped
    resp_ready = 1'b0;
    req_valid = 1'b1; req_addr = 6'd10; req_restore = 1'b1;
    tick();
    req_valid = 1'b0;
    wait_resp0(lat, shifts);
    chk("t3_latency", lat, 33);
    for (int c = 0; c < 10; c++) begin
      req_valid = (c == 3);
      req_addr  = (c == 3) ? 6'd5 : 6'd10;
      tick();
      chk("t3_hold_valid", rvalid0, 1);
      chk("t3_hold_data", rdata0, 32'h12345678);
      chk("t3_hold_addr", raddr0, 10);
      chk("t3_hold_req_ready", rready0, 0);
    end
    req_valid = 1'b0;
    resp_ready = 1'b1;
    tick();
    chk("t3_after_ready", rready0, 1);
    chk("t3_after_valid", rvalid0, 0);
    tick();
    chk("t3_pulse_ignored", busy0, 0);
    chk("t3_restored", bank0[10], 32'h12345678);

    // Back-to-back with req_valid held high
    req_valid = 1'b1; req_addr = 6'd1; req_restore = 1'b1;
    tick();
    req_addr = 6'd2;
    wait_resp0(lat, shifts);
    chk("t4a_latency", lat, 33);
    chk("t4a_data", rdata0, 32'h00000001);
    chk("t4a_addr", raddr0, 1);
    tick();
    chk("t4_gap_ready", rready0, 1);
    tick();
    req_valid = 1'b0;
    chk("t4b_accepted", busy0, 1);
    chk("t4b_sel", sel0, 2);
    wait_resp0(lat, shifts);
    chk("t4b_latency", lat, 33);
    chk("t4b_data", rdata0, 32'hFFFFFFFF);
    chk("t4b_addr", raddr0, 2);
    tick();

    // Async reset in the middle of SHIFT
    req_valid = 1'b1; req_addr = 6'd7; req_restore = 1'b1;
    tick();
    req_valid = 1'b0;
    for (int c = 0; c < 12; c++) tick();
    chk("t5_shifting", shift0, 1);
    #2 reset = 1'b1;
    #1;
    chk("t5_async_shift", shift0, 0);
    chk("t5_async_oe", oe0, 0);
    chk("t5_async_busy", busy0, 0);
    chk("t5_async_valid", rvalid0, 0);
    tick();
    reset = 1'b0;
    chk("t5_req_ready", rready0, 1);
    seen = 0;
    for (int c = 0; c < 40; c++) begin
      tick();
      if (rvalid0 || busy0) seen++;
    end
    chk("t5_no_response", seen, 0);

    // SETTLE = 3 instance
    req_valid1 = 1'b1; req_addr = 6'd9; req_restore = 1'b1;
    tick();
    req_valid1 = 1'b0;
    lat = 0; shifts = 0; lead = 0;
    if (oe1 && !shift1) lead++;
    while (lat < 100) begin
      tick();
      lat++;
      if (oe1 && !shift1) lead++;
      if (shift1) shifts++;
      if (rvalid1) break;
    end
    chk("t6_oe_lead", lead, 3);
    chk("t6_shift_cycles", shifts, 32);
    chk("t6_latency", lat, 35);
    chk("t6_data", rdata1, 32'hCAFEF00D);
    chk("t6_addr", raddr1, 9);
    tick();
    chk("t6_idle_ready", rready1, 1);
    chk("t6_restored", bank1[9], 32'hCAFEF00D);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bank_serial_reader.md
Name: bank_serial_reader

Overview:
- Initiator that reads one register of the 64 x 32 register bank through the bank's serial port.
- Accepts a read request (register address plus restore flag), drives the bank's reg_select, output_enable and shift_right, and samples serial_out LSB-first.
- Reassembles the 32-bit word and returns it on a valid/ready response channel.
- With restore set, loops serial_out back into serial_in so the register is rotated back to its original value (non-destructive read).

Parameters:
- WIDTH, 32: register width; number of shift cycles.
- ADDR_W, 6: register address width; 64 registers.
- SETTLE, 1: cycles from reg_select/output_enable assertion to the first shift; must be >= 1.

Ports:
- clk  input  1  clock, rising-edge.
- reset  input  1  asynchronous, active-high reset.
- req_valid  input  1  read request valid.
- req_ready  output  1  high only in IDLE.
- req_addr  input  ADDR_W  register to read.
- req_restore  input  1  1 = rotate the register back in while reading.
- resp_valid  output  1  read data valid; held until accepted.
- resp_ready  input  1  consumer accepts the response.
- resp_data  output  WIDTH  assembled register value.
- resp_addr  output  ADDR_W  address of the returned data.
- busy  output  1  high in any state except IDLE.
- bank_reg_select  output  ADDR_W  register select to the bank.
- bank_output_enable  output  1  bank tristate enable.
- bank_shift_right  output  1  bank shift-right command.
- bank_serial_in  output  1  serial data into the bank.
- bank_serial_out  input  1  serial data from the bank; carries bit 0 of the selected register.

Behaviour:
- States: IDLE, SETUP, SHIFT, DONE. Register all outputs except bank_serial_in.
- Reset (async, any state): state = IDLE; counter = 0; resp_data = 0; resp_addr = 0; resp_valid = 0; busy = 0; all bank_* outputs = 0; latched restore = 0; req_ready = 1 after reset release.
- IDLE:
  - req_ready = 1.
  - On req_valid & req_ready, latch req_addr and req_restore, clear the assembly register, load counter = SETTLE, go to SETUP.
- SETUP:
  - bank_reg_select = latched address; bank_output_enable = 1; bank_shift_right = 0.
  - Decrement counter. When it reaches 1, load counter = WIDTH and go to SHIFT.
- SHIFT (exactly WIDTH cycles):
  - bank_output_enable = 1; bank_shift_right = 1.
  - Each rising edge: data <= {bank_serial_out, data[WIDTH-1:1]}; decrement counter.
  - After the WIDTH-th shift edge, go to DONE. Bit k of the register is sampled on the k-th shift edge, so resp_data[k] = original bit k.
- bank_serial_in is combinational: bank_serial_out & latched restore & (state == SHIFT); otherwise 0.
  - restore = 1: register equals its original value after WIDTH shifts.
  - restore = 0: register is all zeros after WIDTH shifts.
- DONE:
  - bank_shift_right = 0; bank_output_enable = 0; resp_valid = 1.
  - resp_data and resp_addr are stable until resp_valid & resp_ready, then go to IDLE.
- Latency: the accept edge is edge 0. resp_valid rises after edge SETTLE + WIDTH (33 with defaults). Minimum request-to-request spacing is SETTLE + WIDTH + 2 cycles.
- Simultaneous events:
  - req_valid outside IDLE is ignored; it is not queued.
  - resp_ready in the first DONE cycle completes the response in one cycle.
  - resp_ready while not resp_valid has no effect.
- Reset mid-SHIFT: operation is abandoned and bank controls drop immediately (async). The target register is left partially shifted; the consumer must reload it. No response is produced.
- bank_reg_select holds its value in DONE and returns to 0 in IDLE.

Test Plan:
- Bank model register 5 = 0xDEADBEEF; request addr 5, restore = 1, resp_ready tied high -> resp_valid on cycle 33 after accept, resp_data = 0xDEADBEEF, resp_addr = 5, register 5 still 0xDEADBEEF, bank_shift_right high for exactly 32 cycles.
- Register 63 = 0x80000001; request with restore = 0 -> resp_data = 0x80000001; register 63 = 0x00000000 afterwards.
- Hold resp_ready low for 10 cycles after resp_valid -> resp_valid, resp_data and resp_addr stable; req_ready stays 0 and a req_valid pulse in that window is ignored; one cycle after accept, req_ready = 1.
- Back-to-back: req_valid held high with addr 1 (0x00000001) then addr 2 (0xFFFFFFFF) -> two responses in order with correct data; second accept occurs exactly 1 cycle after the first response handshake.
- Assert reset asynchronously at shift cycle 12 of a read -> bank_shift_right, bank_output_enable, busy and resp_valid are 0 before the next clock edge; req_ready = 1 after reset release; no response is emitted.
- SETTLE = 3 build: bank_output_enable leads bank_shift_right by 3 cycles; resp_valid appears 35 cycles after accept; data is correct.
